// File: rtl/out_serial_tx.sv
// Buffered 8N1 serial transmitter fed by the CPU output strobe.
// A small FIFO absorbs output bytes; an FSM drains them LSB first on tx.
module out_serial_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          out_strobe,
   input  logic [7:0]                    out_data,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [LW-1:0] LVL_ONE   = LW'(1);
   localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
   localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t          state_r;
   logic [7:0]      mem_r [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [LW-1:0]   level_r;
   logic [CW-1:0]   baud_cnt_r;
   logic [2:0]      bit_idx_r;
   logic [7:0]      shift_r;
   logic            tx_r;
   logic            busy_r;
   logic            overflow_r;

   logic            baud_end_s;
   logic            fifo_empty_s;
   logic            pop_s;
   logic            push_s;
   logic            to_idle_s;
   logic [LW-1:0]   level_next_s;

   assign baud_end_s   = (baud_cnt_r == BAUD_LAST);
   assign fifo_empty_s = (level_r == {LW{1'b0}});

   // Pop/push decisions; a pop on the same edge frees room for a push at full.
   always_comb begin
      pop_s     = 1'b0;
      to_idle_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            pop_s     = !fifo_empty_s;
            to_idle_s = fifo_empty_s;
         end
         ST_STOP: begin
            if (baud_end_s) begin
               pop_s     = !fifo_empty_s;
               to_idle_s = fifo_empty_s;
            end else begin
               pop_s     = 1'b0;
               to_idle_s = 1'b0;
            end
         end
         default: begin
            pop_s     = 1'b0;
            to_idle_s = 1'b0;
         end
      endcase
      push_s = out_strobe && ((level_r != LVL_FULL) || pop_s);
      case ({push_s, pop_s})
         2'b10:   level_next_s = level_r + LVL_ONE;
         2'b01:   level_next_s = level_r - LVL_ONE;
         default: level_next_s = level_r;
      endcase
   end

   // FIFO storage, pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         level_r    <= {LW{1'b0}};
         overflow_r <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= out_data;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r <= level_next_s;
         if (out_strobe && !push_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Frame sequencer; tx is set for the state being entered so it stays registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         baud_cnt_r <= {CW{1'b0}};
         bit_idx_r  <= 3'd0;
         shift_r    <= 8'h00;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         busy_r <= !to_idle_s || (level_next_s != {LW{1'b0}});
         case (state_r)
            ST_IDLE: begin
               baud_cnt_r <= {CW{1'b0}};
               if (pop_s) begin
                  state_r <= ST_START;
                  shift_r <= mem_r[rd_ptr_r];
                  tx_r    <= 1'b0;
               end else begin
                  tx_r <= 1'b1;
               end
            end
            ST_START: begin
               if (baud_end_s) begin
                  state_r    <= ST_DATA;
                  baud_cnt_r <= {CW{1'b0}};
                  bit_idx_r  <= 3'd0;
                  tx_r       <= shift_r[0];
               end else begin
                  baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                  tx_r       <= 1'b0;
               end
            end
            ST_DATA: begin
               if (baud_end_s) begin
                  baud_cnt_r <= {CW{1'b0}};
                  if (bit_idx_r == 3'd7) begin
                     state_r   <= ST_STOP;
                     bit_idx_r <= 3'd0;
                     tx_r      <= 1'b1;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                     shift_r   <= {1'b0, shift_r[7:1]};
                     tx_r      <= shift_r[1];
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + BAUD_ONE;
               end
            end
            ST_STOP: begin
               if (baud_end_s) begin
                  baud_cnt_r <= {CW{1'b0}};
                  if (pop_s) begin
                     state_r <= ST_START;
                     shift_r <= mem_r[rd_ptr_r];
                     tx_r    <= 1'b0;
                  end else begin
                     state_r <= ST_IDLE;
                     tx_r    <= 1'b1;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                  tx_r       <= 1'b1;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               baud_cnt_r <= {CW{1'b0}};
               tx_r       <= 1'b1;
            end
         endcase
      end
   end

   assign tx       = tx_r;
   assign busy     = busy_r;
   assign level    = level_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_out_serial_tx.sv
// Self-checking bench for out_serial_tx: directed tables and sequences plus
// randomized traffic compared against a frame-level reference model.
module tb_out_serial_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       out_strobe = 1'b0;
   logic [7:0] out_data = 8'h00;

   logic tx4, busy4, ovf4, tx2, busy2, ovf2, tx7, busy7, ovf7;
   logic [2:0] level4, level2, level7;

   int checks = 0;
   int failures = 0;

   out_serial_tx dut4 (.clk(clk), .reset(reset), .out_strobe(out_strobe), .out_data(out_data),
                       .tx(tx4), .busy(busy4), .level(level4), .overflow(ovf4));
   out_serial_tx #(.CLKS_PER_BIT(2)) dut2 (.clk(clk), .reset(reset), .out_strobe(out_strobe),
                       .out_data(out_data), .tx(tx2), .busy(busy2), .level(level2), .overflow(ovf2));
   out_serial_tx #(.CLKS_PER_BIT(7)) dut7 (.clk(clk), .reset(reset), .out_strobe(out_strobe),
                       .out_data(out_data), .tx(tx7), .busy(busy7), .level(level7), .overflow(ovf7));

   always #5 clk = ~clk;

   // Reference model for dut4 (4 clocks/bit, depth 4): queue + frame cycle counter.
   logic [7:0] mq[$];
   logic       m_active = 1'b0;
   int         m_t = 0;
   logic [7:0] m_cur = 8'h00;
   logic       m_ovf = 1'b0;

   bit cap4[$], cap2[$], cap7[$], bz2[$], bz7[$];
   logic [7:0] dec_bytes[$];
   int         dec_starts[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_update();
      bit ending, pop, accept;
      if (reset) begin
         mq.delete();
         m_active = 1'b0;
         m_t = 0;
         m_ovf = 1'b0;
      end else begin
         ending = m_active && (m_t == 39);
         pop    = (mq.size() > 0) && (!m_active || ending);
         accept = out_strobe && ((mq.size() < 4) || pop);
         if (pop) begin
            m_cur = mq.pop_front();
            m_t = 0;
            m_active = 1'b1;
         end else if (ending) begin
            m_active = 1'b0;
         end else if (m_active) begin
            m_t++;
         end
         if (accept) mq.push_back(out_data);
         else if (out_strobe) m_ovf = 1'b1;
      end
   endtask

   function automatic logic model_tx();
      int b;
      if (!m_active) return 1'b1;
      b = m_t / 4;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_cur[b-1];
   endfunction

   // One clock edge with the given inputs; outputs sampled on the following falling edge.
   task automatic step(input logic s, input logic [7:0] d);
      out_strobe = s;
      out_data = d;
      @(posedge clk);
      model_update();
      @(negedge clk);
      cap4.push_back(tx4); cap2.push_back(tx2); cap7.push_back(tx7);
      bz2.push_back(busy2); bz7.push_back(busy7);
   endtask

   task automatic clear_caps();
      cap4.delete(); cap2.delete(); cap7.delete(); bz2.delete(); bz7.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 8'h00);
      reset = 1'b0;
   endtask

   task automatic drain(input string name, input int maxc);
      int n = 0;
      while (busy4 && n < maxc) begin
         step(1'b0, 8'h00);
         n++;
      end
      check(name, busy4, 1'b0);
   endtask

   task automatic decode(input bit q[$], input int c);
      int j = 0;
      logic [7:0] b;
      dec_bytes.delete();
      dec_starts.delete();
      while (j + 10*c <= q.size()) begin
         if (q[j] == 1'b0) begin
            for (int i = 0; i < 8; i++) b[i] = q[j + c*(1+i) + c/2];
            check("stop_bit", q[j + 9*c + c/2], 1'b1);
            dec_bytes.push_back(b);
            dec_starts.push_back(j);
            j += 10*c;
         end else begin
            j++;
         end
      end
   endtask

   task automatic check_bytes(input string name, input logic [7:0] exp[$]);
      check({name, "_count"}, dec_bytes.size(), exp.size());
      for (int i = 0; i < exp.size() && i < dec_bytes.size(); i++)
         check(name, dec_bytes[i], exp[i]);
   endtask

   typedef struct {
      logic       strobe;
      logic [7:0] data;
      logic       exp_tx;
      logic [2:0] exp_level;
      logic       exp_busy;
      logic       exp_ovf;
   } vec_t;

   vec_t tbl[7];
   logic [7:0] exp_q[$];
   logic [7:0] a5;
   logic       exp_tx;
   int         zeros, busys, first0;

   initial begin
      tbl[0] = '{1'b1, 8'h00, 1'b1, 3'd1, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 8'h01, 1'b0, 3'd1, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 8'h02, 1'b0, 3'd2, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 8'h03, 1'b0, 3'd3, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 8'h04, 1'b0, 3'd4, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 8'h05, 1'b0, 3'd4, 1'b1, 1'b1};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b1};

      @(negedge clk);
      reset = 1'b1;
      step(1'b0, 8'h00);
      step(1'b1, 8'hEE);
      reset = 1'b0;
      check("reset_tx", tx4, 1'b1);
      check("reset_busy", busy4, 1'b0);
      check("reset_level", level4, 3'd0);
      check("reset_ovf", ovf4, 1'b0);

      // Single byte 0xA5
      clear_caps();
      a5 = 8'hA5;
      step(1'b1, a5);
      check("a5_level_e0", level4, 3'd1);
      check("a5_tx_e0", tx4, 1'b1);
      for (int k = 1; k <= 41; k++) begin
         step(1'b0, 8'h00);
         if (k <= 4) exp_tx = 1'b0;
         else if (k <= 36) exp_tx = a5[(k-5)/4];
         else exp_tx = 1'b1;
         check($sformatf("a5_tx_e%0d", k), tx4, exp_tx);
         if (k == 1) check("a5_level_e1", level4, 3'd0);
         if (k == 40) check("a5_busy_e40", busy4, 1'b1);
      end
      check("a5_busy_e41", busy4, 1'b0);
      check("a5_level_e41", level4, 3'd0);

      // Back-to-back frames
      do_reset();
      clear_caps();
      step(1'b1, 8'h41);
      step(1'b1, 8'h42);
      drain("b2b_drain", 200);
      decode(cap4, 4);
      exp_q = '{8'h41, 8'h42};
      check_bytes("b2b_byte", exp_q);
      if (dec_starts.size() == 2) check("b2b_gap", dec_starts[1] - dec_starts[0], 40);
      else check("b2b_frames", dec_starts.size(), 2);

      // Overflow table
      do_reset();
      clear_caps();
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].strobe, tbl[i].data);
         check($sformatf("ovf_tbl%0d", i), {tx4, level4, busy4, ovf4},
               {tbl[i].exp_tx, tbl[i].exp_level, tbl[i].exp_busy, tbl[i].exp_ovf});
      end
      drain("ovf_drain", 400);
      decode(cap4, 4);
      exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      check_bytes("ovf_byte", exp_q);
      check("ovf_sticky", ovf4, 1'b1);

      // Reset during DATA bit 3 with two bytes queued; strobe during reset ignored
      step(1'b1, 8'h20);
      step(1'b1, 8'h21);
      step(1'b1, 8'h22);
      for (int e = 3; e <= 17; e++) step(1'b0, 8'h00);
      check("rst_pre_level", level4, 3'd2);
      check("rst_pre_ovf", ovf4, 1'b1);
      reset = 1'b1;
      step(1'b1, 8'h77);
      reset = 1'b0;
      check("rst_mid", {tx4, level4, busy4, ovf4}, {1'b1, 3'd0, 1'b0, 1'b0});
      clear_caps();
      step(1'b1, 8'h5A);
      drain("rst_drain", 200);
      decode(cap4, 4);
      exp_q = '{8'h5A};
      check_bytes("rst_byte", exp_q);

      // Push at full on the STOP->START pop edge
      do_reset();
      clear_caps();
      for (int i = 0; i <= 4; i++) step(1'b1, 8'h10 + 8'(i));
      check("full_level_e4", level4, 3'd4);
      for (int e = 5; e <= 40; e++) step(1'b0, 8'h00);
      check("full_e40", {tx4, level4}, {1'b1, 3'd4});
      step(1'b1, 8'h99);
      check("full_pushpop", {tx4, level4, ovf4}, {1'b0, 3'd4, 1'b0});
      drain("full_drain", 400);
      decode(cap4, 4);
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h99};
      check_bytes("full_byte", exp_q);
      check("full_ovf_end", ovf4, 1'b0);

      // Baud parameter: 0xFF at 2 and 7 clocks per bit
      do_reset();
      clear_caps();
      step(1'b1, 8'hFF);
      for (int k = 1; k < 80; k++) step(1'b0, 8'h00);
      zeros = 0; busys = 0; first0 = -1;
      foreach (cap2[i]) begin
         if (!cap2[i]) begin zeros++; if (first0 < 0) first0 = i; end
         if (bz2[i]) busys++;
      end
      check("baud2_start_first", first0, 1);
      check("baud2_start_len", zeros, 2);
      check("baud2_frame_len", busys - 1, 20);
      zeros = 0; busys = 0; first0 = -1;
      foreach (cap7[i]) begin
         if (!cap7[i]) begin zeros++; if (first0 < 0) first0 = i; end
         if (bz7[i]) busys++;
      end
      check("baud7_start_first", first0, 1);
      check("baud7_start_len", zeros, 7);
      check("baud7_frame_len", busys - 1, 70);
      decode(cap7, 7);
      exp_q = '{8'hFF};
      check_bytes("baud7_byte", exp_q);

      // Randomized traffic against the reference model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 499) == 0);
         step($urandom_range(0, 99) < 35, 8'($urandom));
         check($sformatf("rand_c%0d", n), {tx4, level4, busy4, ovf4},
               {model_tx(), 3'(mq.size()), m_active || (mq.size() > 0), m_ovf});
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
